// File: rtl/resize_accel_mul_pkg.sv
// Shared widths, saturation limits and parameter checks for the resize_accel multiplier.
// Latency: none (package only).
// Backpressure: not applicable.
package resize_accel_mul_pkg;

  // Signed width that holds any product of the extended operands.
  function automatic int prod_width(int a_width, int b_width);
    return a_width + b_width + 1;
  endfunction

  // Accumulator width: product width plus guard bits for group sums.
  function automatic int acc_width(int a_width, int b_width, int acc_guard);
    return prod_width(a_width, b_width) + acc_guard;
  endfunction

  // Largest value representable in the output format.
  function automatic longint sat_max(int p_width, bit out_signed);
    longint one = 1;
    if (out_signed) return (one <<< (p_width - 1)) - 1;
    return (one <<< p_width) - 1;
  endfunction

  // Smallest value representable in the output format.
  function automatic longint sat_min(int p_width, bit out_signed);
    longint one = 1;
    if (out_signed) return -(one <<< (p_width - 1));
    return 0;
  endfunction

  // Legal parameter combinations; saturation limits are kept in 64-bit
  // arithmetic, so the output width is capped below that.
  function automatic bit params_ok(int a_w, int b_w, int p_w, int num_stage,
                                   int shift, int acc_guard, int tag_w);
    return (a_w >= 1) && (b_w >= 1) && (p_w >= 2) && (p_w <= 62) &&
           (num_stage >= 3) && (num_stage <= 8) &&
           (shift >= 0) && (shift <= a_w + b_w - 1) &&
           (acc_guard >= 0) && (tag_w >= 1);
  endfunction

endpackage

// File: rtl/resize_accel_mul_pipe_if.sv
// Input/output beat bundle for the resize_accel multiply pipe.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry valid-ready flow control.
// Ports: in_valid/in_ready/in_a/in_b/in_acc/in_last/in_tag (input beat),
//        out_valid/out_ready/out_p/out_ovf/out_tag (result beat).
// master = upstream source and downstream sink; slave = the multiply pipe.
interface resize_accel_mul_pipe_if #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int P_WIDTH   = 22,
  parameter int TAG_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_acc;
  logic                 in_last;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [P_WIDTH-1:0]   out_p;
  logic                 out_ovf;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_acc, in_last, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_ovf, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_acc, in_last, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_ovf, out_tag
  );
endinterface

// File: rtl/resize_accel_mul_core.sv
// Operand register, product register and delay stages (DSP-shaped multiply).
// Latency: NUM_STAGE-1 cycles from in_vld to out_vld.
// Backpressure: every stage holds while ce is low.
// Ports: clk, reset_n, ce; in_vld/in_a/in_b/in_side beat in;
//        out_vld/out_prod/out_side beat out (side bits travel with the beat).
module resize_accel_mul_core
  import resize_accel_mul_pkg::*;
#(
  parameter int A_WIDTH    = 16,
  parameter int B_WIDTH    = 16,
  parameter bit A_SIGNED   = 1'b0,
  parameter bit B_SIGNED   = 1'b0,
  parameter int NUM_STAGE  = 4,
  parameter int SIDE_WIDTH = 10
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          ce,
  input  logic                                          in_vld,
  input  logic [A_WIDTH-1:0]                            in_a,
  input  logic [B_WIDTH-1:0]                            in_b,
  input  logic [SIDE_WIDTH-1:0]                         in_side,
  output logic                                          out_vld,
  output logic signed [prod_width(A_WIDTH, B_WIDTH)-1:0] out_prod,
  output logic [SIDE_WIDTH-1:0]                         out_side
);
  localparam int PW = prod_width(A_WIDTH, B_WIDTH);
  // Registers S2 .. S(NUM_STAGE-1); S2 is the product register.
  localparam int NR = NUM_STAGE - 2;

  logic                   s1_vld;
  logic signed [PW-1:0]   s1_a;
  logic signed [PW-1:0]   s1_b;
  logic [SIDE_WIDTH-1:0]  s1_side;
  logic                   vld_q  [NR];
  logic signed [PW-1:0]   prod_q [NR];
  logic [SIDE_WIDTH-1:0]  side_q [NR];

  // Only the valid bits are reset; data registers stay reset-free for DSP packing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < NR; i++) vld_q[i] <= 1'b0;
    end else if (ce) begin
      s1_vld   <= in_vld;
      vld_q[0] <= s1_vld;
      for (int i = 1; i < NR; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      // Extend to PW bits so unsigned operands multiply correctly as signed.
      s1_a      <= {{(PW-A_WIDTH){A_SIGNED & in_a[A_WIDTH-1]}}, in_a};
      s1_b      <= {{(PW-B_WIDTH){B_SIGNED & in_b[B_WIDTH-1]}}, in_b};
      s1_side   <= in_side;
      prod_q[0] <= s1_a * s1_b;
      side_q[0] <= s1_side;
      for (int i = 1; i < NR; i++) begin
        prod_q[i] <= prod_q[i-1];
        side_q[i] <= side_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[NR-1];
  assign out_prod = prod_q[NR-1];
  assign out_side = side_q[NR-1];

endmodule

// File: rtl/resize_accel_mul_pipe.sv
// Pipelined multiply / multiply-accumulate with shift and saturation for resize_accel.
// Latency: NUM_STAGE cycles from acceptance to out_valid; 1 beat/cycle throughput.
// Backpressure: global stall when out_valid && !out_ready; in_ready = !out_valid || out_ready.
// Ports: clk, reset_n (async, active-low), bus (resize_accel_mul_pipe_if.slave).
// Build option: RESIZE_MUL_ROUND_EN adds 2^(SHIFT-1) before the shift (round half up).
module resize_accel_mul_pipe
  import resize_accel_mul_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int P_WIDTH   = 22,
  parameter bit A_SIGNED  = 1'b0,
  parameter bit B_SIGNED  = 1'b0,
  parameter int NUM_STAGE = 4,
  parameter int SHIFT     = 0,
  parameter int ACC_GUARD = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  resize_accel_mul_pipe_if.slave bus
);
  localparam int PW  = prod_width(A_WIDTH, B_WIDTH);
  localparam int AW  = acc_width(A_WIDTH, B_WIDTH, ACC_GUARD);
  // One spare bit so the rounding add cannot wrap; at least 64 so the
  // saturation limits are always representable.
  localparam int CW  = (AW + 1 > 64) ? AW + 1 : 64;
  localparam int SW  = TAG_WIDTH + 2;
  localparam bit OUT_SIGNED = A_SIGNED | B_SIGNED;
  localparam logic signed [CW-1:0] P_MAX = CW'(sat_max(P_WIDTH, OUT_SIGNED));
  localparam logic signed [CW-1:0] P_MIN = CW'(sat_min(P_WIDTH, OUT_SIGNED));
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef RESIZE_MUL_ROUND_EN
  localparam logic signed [CW-1:0] RND = (SHIFT > 0) ? (CW'(1) << RND_SH) : '0;
`else
  localparam logic signed [CW-1:0] RND = '0;
`endif

  if (!params_ok(A_WIDTH, B_WIDTH, P_WIDTH, NUM_STAGE, SHIFT, ACC_GUARD, TAG_WIDTH)) begin : g_param_err
    $error("resize_accel_mul_pipe: illegal parameter set");
  end

  logic                    ce;
  logic                    c_vld;
  logic signed [PW-1:0]    c_prod;
  logic [SW-1:0]           c_side;
  logic                    c_acc;
  logic                    c_last;
  logic [TAG_WIDTH-1:0]    c_tag;

  logic signed [AW-1:0]    acc_q;
  logic                    grp_open_q;
  logic                    out_vld_q;
  logic [P_WIDTH-1:0]      out_p_q;
  logic                    out_ovf_q;
  logic [TAG_WIDTH-1:0]    out_tag_q;

  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    emit_val;
  logic                    emit;
  logic signed [CW-1:0]    val_w;
  logic signed [CW-1:0]    val_sh;
  logic [P_WIDTH-1:0]      p_nxt;
  logic                    ovf_nxt;

  assign ce           = !out_vld_q || bus.out_ready;
  assign bus.in_ready = ce;

  resize_accel_mul_core #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .A_SIGNED   (A_SIGNED),
    .B_SIGNED   (B_SIGNED),
    .NUM_STAGE  (NUM_STAGE),
    .SIDE_WIDTH (SW)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .ce       (ce),
    .in_vld   (bus.in_valid),
    .in_a     (bus.in_a),
    .in_b     (bus.in_b),
    .in_side  ({bus.in_acc, bus.in_last, bus.in_tag}),
    .out_vld  (c_vld),
    .out_prod (c_prod),
    .out_side (c_side)
  );

  assign c_acc  = c_side[SW-1];
  assign c_last = c_side[SW-2];
  assign c_tag  = c_side[TAG_WIDTH-1:0];

  // Final stage: accumulate, round/shift, saturate.
  always_comb begin
    prod_ext = AW'(c_prod);
    sum      = (grp_open_q ? acc_q : '0) + prod_ext;
    emit_val = c_acc ? sum : prod_ext;
    // Middle-of-group beats keep their pipeline slot but leave a bubble.
    emit     = c_vld && (!c_acc || c_last);
    val_w    = CW'(emit_val) + RND;
    val_sh   = val_w >>> SHIFT;
    p_nxt    = val_sh[P_WIDTH-1:0];
    ovf_nxt  = 1'b0;
    if (val_sh > P_MAX) begin
      p_nxt   = P_MAX[P_WIDTH-1:0];
      ovf_nxt = 1'b1;
    end else if (val_sh < P_MIN) begin
      p_nxt   = P_MIN[P_WIDTH-1:0];
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_p_q    <= '0;
      out_ovf_q  <= 1'b0;
      out_tag_q  <= '0;
      acc_q      <= '0;
      grp_open_q <= 1'b0;
    end else if (ce) begin
      out_vld_q <= emit;
      if (emit) begin
        out_p_q   <= p_nxt;
        out_ovf_q <= ovf_nxt;
        out_tag_q <= c_tag;
      end
      // Standalone beats leave an open group untouched.
      if (c_vld && c_acc) begin
        if (c_last) begin
          acc_q      <= '0;
          grp_open_q <= 1'b0;
        end else begin
          acc_q      <= sum;
          grp_open_q <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_p     = out_p_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_tag   = out_tag_q;

endmodule
